// File: rtl/fir_pkg.sv
// Shared constants for the FIR input driver and the FIR core:
// default widths, driver FSM state encoding and a counter-width helper.
package fir_pkg;

    localparam int TAP_SIZE_DEF       = 6;
    localparam int NBR_OF_TAPS_DEF    = 10;
    localparam int X_N_SIZE_DEF       = 8;
    localparam int Y_N_SIZE_DEF       = 14;
    localparam int SETUP_CYCLES_DEF   = 4;
    localparam int RESULT_LATENCY_DEF = 2;

    // Driver FSM state encoding
    localparam logic [2:0] ST_STARTUP = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_COEFF   = 3'd2;
    localparam logic [2:0] ST_GAP     = 3'd3;
    localparam logic [2:0] ST_STREAM  = 3'd4;

    // Bits needed to hold values 0..max_val (at least one bit)
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fir_result_capture.sv
// Delays the FIR input strobe by RESULT_LATENCY cycles and captures the
// FIR output into a registered result port with a one-cycle valid strobe.
module fir_result_capture
    import fir_pkg::*;
#(
    parameter int RESULT_LATENCY = RESULT_LATENCY_DEF,
    parameter int Y_N_SIZE       = Y_N_SIZE_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tvalid_i,
    input  logic signed [Y_N_SIZE-1:0] y_n_i,
    output logic signed [Y_N_SIZE-1:0] res_data_o,
    output logic                       res_valid_o
);

    logic [RESULT_LATENCY-1:0]  vld_pipe_q;
    logic signed [Y_N_SIZE-1:0] res_data_q;
    logic                       res_valid_q;

    // Valid delay line; its last stage marks the cycle fir y_n holds a result
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe_q  <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            vld_pipe_q[0] <= tvalid_i;
            for (int i = 1; i < RESULT_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            end
            res_valid_q <= vld_pipe_q[RESULT_LATENCY-1];
            if (vld_pipe_q[RESULT_LATENCY-1]) begin
                res_data_q <= y_n_i;
            end
        end
    end

    assign res_data_o  = res_data_q;
    assign res_valid_o = res_valid_q;

endmodule

// File: rtl/fir_stream_driver.sv
// Upstream driver for the FIR core: turns a tagged ready/valid beat stream
// into registered x_n / set_coeffs / tvalid pin activity with a one-cycle
// gap on every coefficient<->sample mode change, tracks coefficient loading
// and captures the FIR result.
module fir_stream_driver
    import fir_pkg::*;
#(
    parameter int TAP_SIZE       = TAP_SIZE_DEF,
    parameter int NBR_OF_TAPS    = NBR_OF_TAPS_DEF,
    parameter int X_N_SIZE       = X_N_SIZE_DEF,
    parameter int Y_N_SIZE       = Y_N_SIZE_DEF,
    parameter int SETUP_CYCLES   = SETUP_CYCLES_DEF,
    parameter int RESULT_LATENCY = RESULT_LATENCY_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [X_N_SIZE-1:0]        up_data,
    input  logic                       up_is_coeff,
    input  logic                       up_valid,
    output logic                       up_ready,
    output logic [X_N_SIZE-1:0]        fir_x_n,
    output logic                       fir_set_coeffs,
    output logic                       fir_tvalid,
    input  logic signed [Y_N_SIZE-1:0] fir_y_n,
    output logic signed [Y_N_SIZE-1:0] res_data,
    output logic                       res_valid,
    output logic                       coeffs_loaded,
    output logic                       sample_err
);

    localparam int SU_W  = cnt_width(SETUP_CYCLES - 1);
    localparam int CNT_W = cnt_width(NBR_OF_TAPS);
    localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NBR_OF_TAPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Parameter sanity: the FIR only looks at the low TAP_SIZE bits of the bus
    if (TAP_SIZE < 1 || TAP_SIZE > X_N_SIZE) begin : g_bad_tap_size
        $error("TAP_SIZE must lie within 1..X_N_SIZE");
    end
    if (RESULT_LATENCY < 1 || RESULT_LATENCY > 7) begin : g_bad_latency
        $error("RESULT_LATENCY must lie within 1..7");
    end

    logic [2:0]          state_q, state_d;
    logic [SU_W-1:0]     su_cnt_q, su_cnt_d;
    logic [CNT_W-1:0]    coef_cnt_q, coef_cnt_d;
    logic [X_N_SIZE-1:0] x_n_q;
    logic                set_q;
    logic                tvalid_q;
    logic                err_q;
    logic                mode_clash;
    logic                ready;
    logic                accept;
    logic                loaded;

    assign loaded = (coef_cnt_q == CNT_FULL);
    assign accept = up_valid & ready;

    // Ready depends only on state and the offered tag; a tag opposite to the
    // current mode is refused so the FSM can insert the gap cycle
    always_comb begin
        mode_clash = 1'b0;
        ready      = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_COEFF: begin
                mode_clash = ~up_is_coeff;
                ready      = up_is_coeff;
            end
            ST_STREAM: begin
                mode_clash = up_is_coeff;
                ready      = ~up_is_coeff;
            end
            default: ;
        endcase
    end

    // Mode FSM: startup wait, idle, coefficient/stream modes and the gap
    always_comb begin
        state_d  = state_q;
        su_cnt_d = su_cnt_q;
        case (state_q)
            ST_STARTUP: begin
                if (su_cnt_q == SU_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    su_cnt_d = su_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_d = up_is_coeff ? ST_COEFF : ST_STREAM;
                end
            end
            ST_COEFF, ST_STREAM: begin
                if (!up_valid) begin
                    state_d = ST_IDLE;
                end else if (mode_clash) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_STARTUP;
        endcase
    end

    // Coefficient count: saturates at a full load, a new load restarts at 1
    always_comb begin
        coef_cnt_d = coef_cnt_q;
        if (accept && up_is_coeff) begin
            coef_cnt_d = loaded ? CNT_ONE : (coef_cnt_q + 1'b1);
        end
    end

    // State, counters, registered FIR pins and the sticky sample error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_STARTUP;
            su_cnt_q   <= '0;
            coef_cnt_q <= '0;
            x_n_q      <= '0;
            set_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            su_cnt_q   <= su_cnt_d;
            coef_cnt_q <= coef_cnt_d;
            if (accept) begin
                x_n_q <= up_data;
            end
            set_q    <= accept & up_is_coeff;
            tvalid_q <= accept & ~up_is_coeff;
            err_q    <= err_q | (accept & ~up_is_coeff & ~loaded);
        end
    end

    fir_result_capture #(
        .RESULT_LATENCY (RESULT_LATENCY),
        .Y_N_SIZE       (Y_N_SIZE)
    ) u_capture (
        .clk         (clk),
        .reset       (reset),
        .tvalid_i    (tvalid_q),
        .y_n_i       (fir_y_n),
        .res_data_o  (res_data),
        .res_valid_o (res_valid)
    );

    assign up_ready       = ready;
    assign fir_x_n        = x_n_q;
    assign fir_set_coeffs = set_q;
    assign fir_tvalid     = tvalid_q;
    assign coeffs_loaded  = loaded;
    assign sample_err     = err_q;

endmodule
